// File: rtl/fmap_stream_tx.sv
// Feature-map transmitter: captures one WIDTH x WIDTH frame of CH-channel pixels
// and replays it as a contiguous one-pixel-per-cycle stream to the next layer.
module fmap_stream_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int CH         = 32,
  parameter int WIDTH      = 14,
  parameter int AUTO_START = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH*CH-1:0]   wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       start,
  output logic [DATA_WIDTH*CH-1:0]   o_data,
  output logic                       valid_out,
  output logic                       o_last,
  output logic                       frame_full,
  output logic                       busy,
  output logic                       done,
  output logic                       err_ovf
);

  localparam int DIM = WIDTH * WIDTH;
  localparam int PW  = DATA_WIDTH * CH;
  localparam int AW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DIM - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_FULL = 2'd1,
    S_SEND = 2'd2
  } state_e;

  state_e          state_r;
  state_e          state_nxt_s;
  logic [AW-1:0]   wr_addr_r;
  logic [AW-1:0]   rd_addr_r;
  logic [PW-1:0]   mem_r [DIM];
  logic [PW-1:0]   o_data_r;
  logic            valid_r;
  logic            last_r;
  logic            done_r;
  logic            err_r;
  logic            wr_en_s;
  logic            wr_last_s;
  logic            rd_en_s;
  logic            rd_last_s;
  logic            go_s;

  // Write/read strobes and the launch condition out of FULL
  always_comb begin
    wr_en_s   = (state_r == S_FILL) && wr_valid;
    wr_last_s = wr_en_s && (wr_addr_r == LAST_ADDR);
    rd_en_s   = (state_r == S_SEND);
    rd_last_s = rd_en_s && (rd_addr_r == LAST_ADDR);
    go_s      = (AUTO_START != 0) || start;
  end

  // Next-state logic; start outside FULL is simply not looked at
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FILL: begin
        if (wr_last_s) state_nxt_s = S_FULL;
        else           state_nxt_s = S_FILL;
      end
      S_FULL: begin
        if (go_s) state_nxt_s = S_SEND;
        else      state_nxt_s = S_FULL;
      end
      S_SEND: begin
        if (rd_last_s) state_nxt_s = S_FILL;
        else           state_nxt_s = S_SEND;
      end
      default: state_nxt_s = S_FILL;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= S_FILL;
    else      state_r <= state_nxt_s;
  end

  // Write and read address counters; rd_addr sits at 0 whenever not replaying
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr_r <= {AW{1'b0}};
      rd_addr_r <= {AW{1'b0}};
    end else begin
      if (wr_last_s)    wr_addr_r <= {AW{1'b0}};
      else if (wr_en_s) wr_addr_r <= wr_addr_r + 1'b1;
      if (!rd_en_s || rd_last_s) rd_addr_r <= {AW{1'b0}};
      else                       rd_addr_r <= rd_addr_r + 1'b1;
    end
  end

  // Frame buffer write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_addr_r] <= wr_data;
  end

  // Registered read port with aligned valid/last, done pulse and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data_r <= {PW{1'b0}};
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      if (rd_en_s) o_data_r <= mem_r[rd_addr_r];
      valid_r <= rd_en_s;
      last_r  <= rd_last_s;
      done_r  <= last_r;
      err_r   <= err_r | (wr_valid && (state_r != S_FILL));
    end
  end

  assign wr_ready   = (state_r == S_FILL);
  assign frame_full = (state_r == S_FULL);
  // busy spans the whole replay including the final pixel leaving the read register
  assign busy       = (state_r == S_SEND) || valid_r;
  assign o_data     = o_data_r;
  assign valid_out  = valid_r;
  assign o_last     = last_r;
  assign done       = done_r;
  assign err_ovf    = err_r;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed self-checking bench for fmap_stream_tx: one manual-start instance
// and one AUTO_START instance, selected by tb_sel.
module tb_fmap_stream_tx;

  localparam int DW    = 32;
  localparam int CH    = 32;
  localparam int WIDTH = 14;
  localparam int DIM   = WIDTH * WIDTH;
  localparam int PW    = DW * CH;

  logic          clk;
  logic          rst;
  logic [PW-1:0] wr_data;
  logic          wr_valid;
  logic          start;
  logic          tb_sel;

  logic          wr_valid_m, wr_valid_a, start_m, start_a;
  logic          wr_ready_m, wr_ready_a, valid_m, valid_a, last_m, last_a;
  logic          full_m, full_a, busy_m, busy_a, done_m, done_a, err_m, err_a;
  logic [PW-1:0] o_data_m, o_data_a;

  logic          wr_ready_v, valid_v, last_v, full_v, busy_v, done_v, err_v;
  logic [PW-1:0] od_v;

  int n_checks = 0;
  int n_errs   = 0;

  assign wr_valid_m = wr_valid & ~tb_sel;
  assign wr_valid_a = wr_valid & tb_sel;
  assign start_m    = start & ~tb_sel;
  assign start_a    = start & tb_sel;

  assign wr_ready_v = tb_sel ? wr_ready_a : wr_ready_m;
  assign valid_v    = tb_sel ? valid_a    : valid_m;
  assign last_v     = tb_sel ? last_a     : last_m;
  assign full_v     = tb_sel ? full_a     : full_m;
  assign busy_v     = tb_sel ? busy_a     : busy_m;
  assign done_v     = tb_sel ? done_a     : done_m;
  assign err_v      = tb_sel ? err_a      : err_m;
  assign od_v       = tb_sel ? o_data_a   : o_data_m;

  fmap_stream_tx #(.DATA_WIDTH(DW), .CH(CH), .WIDTH(WIDTH), .AUTO_START(0)) u_dut_m (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid_m), .wr_ready(wr_ready_m),
    .start(start_m), .o_data(o_data_m), .valid_out(valid_m), .o_last(last_m),
    .frame_full(full_m), .busy(busy_m), .done(done_m), .err_ovf(err_m)
  );

  fmap_stream_tx #(.DATA_WIDTH(DW), .CH(CH), .WIDTH(WIDTH), .AUTO_START(1)) u_dut_a (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid_a), .wr_ready(wr_ready_a),
    .start(start_a), .o_data(o_data_a), .valid_out(valid_a), .o_last(last_a),
    .frame_full(full_a), .busy(busy_a), .done(done_a), .err_ovf(err_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int v);
    logic [DW-1:0] w;
    w = DW'(v);
    return {CH{w}};
  endfunction

  // Number of lanes of a pixel word that differ from the expected channel value
  function automatic int lane_err(input logic [PW-1:0] w, input logic [DW-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < CH; k++)
      if (w[k*DW +: DW] !== v) n++;
    return n;
  endfunction

  task automatic chk_pix(input string tag, input int v);
    logic [DW-1:0] e;
    e = DW'(v);
    chk(tag, {32'(lane_err(od_v, e)), od_v[31:0]}, {32'd0, e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writes DIM pixels base+i; optional idle gaps and a start pulse on beat start_at
  task automatic fill(input int base, input bit gaps, input int start_at);
    for (int i = 0; i < DIM; i++) begin
      if (gaps && i > 0) begin
        wr_valid = 1'b0;
        start    = 1'b0;
        step();
      end
      if (i == DIM - 1) chk("full_before_last", 64'(full_v), 64'd0);
      chk("wr_ready_fill", 64'(wr_ready_v), 64'd1);
      wr_valid = 1'b1;
      wr_data  = pix(base + i);
      start    = (i == start_at);
      step();
    end
    wr_valid = 1'b0;
    start    = 1'b0;
    chk("full_after_fill", 64'(full_v), 64'd1);
    chk("wr_ready_full", 64'(wr_ready_v), 64'd0);
    chk("busy_full", 64'(busy_v), 64'd0);
  endtask

  // Caller drives start (or relies on AUTO_START) before the launch edge
  task automatic replay(input int base, input int start_mid);
    step();
    start = 1'b0;
    chk("valid_early", 64'(valid_v), 64'd0);
    chk("busy_enter", 64'(busy_v), 64'd1);
    chk("full_clear", 64'(full_v), 64'd0);
    for (int b = 0; b < DIM; b++) begin
      step();
      start = (b == start_mid);
      chk("valid_beat", 64'(valid_v), 64'd1);
      chk_pix("pixel", base + b);
      chk("last_beat", 64'(last_v), 64'(b == DIM - 1));
      chk("busy_beat", 64'(busy_v), 64'd1);
      if (b < DIM - 1) chk("wr_ready_send", 64'(wr_ready_v), 64'd0);
      else             chk("wr_ready_last", 64'(wr_ready_v), 64'd1);
    end
    start = 1'b0;
    step();
    chk("valid_after", 64'(valid_v), 64'd0);
    chk("done_pulse", 64'(done_v), 64'd1);
    chk("last_after", 64'(last_v), 64'd0);
    chk("busy_after", 64'(busy_v), 64'd0);
    step();
    chk("done_clear", 64'(done_v), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_second_replay", 64'(valid_v), 64'd0);
      chk("idle_fill", 64'(wr_ready_v), 64'd1);
    end
  endtask

  initial begin
    rst      = 1'b0;
    wr_data  = '0;
    wr_valid = 1'b0;
    start    = 1'b0;
    tb_sel   = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_v), 64'd0);
    chk("rst_busy", 64'(busy_v), 64'd0);
    chk("rst_full", 64'(full_v), 64'd0);
    chk("rst_err", 64'(err_v), 64'd0);
    chk("rst_done", 64'(done_v), 64'd0);
    chk_pix("rst_odata", 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("wr_ready_release", 64'(wr_ready_v), 64'd1);

    // Contiguous fill and replay
    fill(0, 1'b0, -1);
    chk("err_clean", 64'(err_v), 64'd0);
    start = 1'b1;
    replay(0, -1);

    // Gapped fill with start on the completing write: start must be ignored
    fill(1000, 1'b1, DIM - 1);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("sim_start_ignored", 64'(busy_v), 64'd0);
      chk("full_held", 64'(full_v), 64'd1);
    end
    start = 1'b1;
    replay(1000, -1);

    // Overflow while FULL
    fill(2000, 1'b0, -1);
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data  = pix(32'h5555_0000 + k);
      chk("wr_ready_ovf", 64'(wr_ready_v), 64'd0);
      step();
    end
    wr_valid = 1'b0;
    chk("err_set", 64'(err_v), 64'd1);
    chk("full_ovf", 64'(full_v), 64'd1);
    start = 1'b1;
    replay(2000, -1);
    chk("err_sticky", 64'(err_v), 64'd1);

    // Start during FILL and mid-SEND has no effect
    fill(3000, 1'b0, 100);
    start = 1'b1;
    replay(3000, 50);

    // Reset in the middle of a replay
    fill(4000, 1'b0, -1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 50; b++) step();
    chk_pix("pre_rst_pixel", 4000 + 49);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(valid_v), 64'd0);
    chk("midrst_busy", 64'(busy_v), 64'd0);
    chk("midrst_last", 64'(last_v), 64'd0);
    chk("midrst_err", 64'(err_v), 64'd0);
    chk_pix("midrst_odata", 0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_ready", 64'(wr_ready_v), 64'd1);
    chk("post_rst_full", 64'(full_v), 64'd0);
    chk("post_rst_valid", 64'(valid_v), 64'd0);
    fill(5000, 1'b0, -1);
    start = 1'b1;
    replay(5000, -1);

    // AUTO_START instance: two frames back to back without start
    tb_sel = 1'b1;
    step();
    chk("auto_idle", 64'(wr_ready_v), 64'd1);
    fill(6000, 1'b0, -1);
    replay(6000, -1);
    fill(7000, 1'b1, -1);
    replay(7000, -1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
